tmds_encoder: RTL and testbench
===============================

Name: tmds_encoder

Overview:
- Per-channel DVI 1.0 TMDS 8b/10b encoder in the pixel clock domain.
- Sits between the VGA timing/pattern generator and the TMDS serializer. Three instances serve the blue, green and red lanes.
- Applies transition minimisation, then DC balancing with a running disparity counter.
- Outputs control tokens during blanking.

Parameters:
- CNT_W, 6: width of the signed running-disparity counter; must be ≥5.
- RST_TOKEN, 2'b00: control code whose token drives out_tmds during reset.

Ports:
- clk_pixel  in  1  pixel clock, rising edge.
- rst_n  in  1  asynchronous reset, active low; deassertion is synchronous to clk_pixel upstream.
- in_data  in  8  pixel component for this lane.
- in_c  in  2  control bits (blue lane {vsync,hsync}; others 00).
- in_blank  in  1  1 = blanking; encode in_c, ignore in_data.
- out_tmds  out  10  TMDS symbol, bit 0 transmitted first.

Behaviour:
- Reset (rst_n=0, async): out_tmds = token(RST_TOKEN), i.e. 10'b1101010100 for 00. cnt=0. All pipeline registers reset to blank with in_c=RST_TOKEN.
- Latency: 2 clk_pixel cycles from input to out_tmds (3 with the optional feature). One symbol every cycle, no stalls, no handshake.
- Stage 1, registered:
  - N1 = popcount(in_data).
  - Use XNOR if N1>4, or if N1==4 and in_data[0]==0; otherwise XOR.
  - q_m[0]=d[0]; q_m[i]=q_m[i-1] op d[i] for i=1..7.
  - q_m[8]=0 for XNOR, 1 for XOR.
  - blank and c are registered alongside.
- Stage 2, registered. Let n1/n0 be the ones/zeros count of q_m[7:0].
  - blank=1: out = token(c) and cnt <= 0. Tokens: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
  - cnt==0 or n1==n0:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (n1−n0) : (n0−n1).
  - (cnt>0 and n1>n0) or (cnt<0 and n0>n1):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2·q_m[8] + (n0−n1).
  - else:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += (n1−n0) − 2·(~q_m[8]).
- Arithmetic: cnt is signed CNT_W. Sum with sign-extended operands. A legal stream never overflows, so no saturation.
- Blank→active boundary: the first active symbol sees cnt=0.
- Active→blank boundary: the token is emitted in the same cycle the blank reaches stage 2.
- Reset mid-frame: immediate token output. The pipeline is flushed to blank.
- in_data during blank does not affect cnt or out_tmds.

Optional Feature:
- Macro TMDS_OUT_REG_EN.
- Defined: adds an output register after stage 2. Latency becomes 3. The reset value is the same token.
- Undefined: out_tmds is driven directly by the stage-2 register, latency 2.
- Encoding and disparity sequence are identical in both builds.

Decomposition:
- Package tmds_pkg holds:
  - the four control-token constants;
  - the CNT_W default;
  - a popcount8 function returning 4 bits.
- Sub-module tmds_qm_stage implements stage 1: in_data/in_c/in_blank → registered q_m[8:0], blank, c.
- tmds_encoder instantiates tmds_qm_stage and contains the disparity stage.

Test Plan:
- Reset with rst_n=0 held over 3 clocks → out_tmds=10'h354 (1101010100), and it asserts immediately without waiting for a clock edge.
- Blank=0 stream of in_data=8'h00 from cnt=0 → after latency, out_tmds = 10'h100, 10'h3FF, 10'h100. cnt sequence = −8, +2, −6.
- Blank=0 with in_data=8'hFF from cnt=0 → out_tmds=10'h200, cnt=−8.
- Blank=1 with in_c stepping 00,01,10,11 → out_tmds = 10'h354, 10'h0AB, 10'h154, 10'h2AB. cnt forced 0; the next active 8'h00 yields 10'h100.
- Random 10k-symbol active/blank mix vs. reference model:
  - bit-exact out_tmds;
  - decoding each symbol returns the original in_data;
  - |cnt| stays ≤ 2^(CNT_W−1)−1.
- Build with TMDS_OUT_REG_EN → same sequences as the scenarios above, delayed by exactly one extra cycle.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the DVI TMDS 8b/10b encoder.
package tmds_pkg;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  localparam int unsigned CNT_W_DEFAULT = 6;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

  function automatic logic [9:0] token(input logic [1:0] c);
    logic [9:0] t;
    unique case (c)
      2'b00:   t = TOKEN_C00;
      2'b01:   t = TOKEN_C01;
      2'b10:   t = TOKEN_C10;
      default: t = TOKEN_C11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// TMDS stage 1: transition-minimising XOR/XNOR chain, registered with blank and control bits.
module tmds_qm_stage
  import tmds_pkg::*;
#(
  parameter logic [1:0] RST_TOKEN = 2'b00
) (
  input  logic       clk_pixel,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic [1:0] in_c,
  input  logic       in_blank,
  output logic [8:0] qm,
  output logic       blank,
  output logic [1:0] c
);

  logic [3:0] n1;
  logic       use_xnor;
  logic [8:0] qm_d, qm_q;
  logic       blank_q;
  logic [1:0] c_q;

  always_comb begin
    n1       = popcount8(in_data);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !in_data[0]);
    qm_d     = '0;
    qm_d[0]  = in_data[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ in_data[i]) : (qm_d[i-1] ^ in_data[i]);
    end
    qm_d[8] = ~use_xnor;
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      qm_q    <= '0;
      blank_q <= 1'b1;
      c_q     <= RST_TOKEN;
    end else begin
      qm_q    <= qm_d;
      blank_q <= in_blank;
      c_q     <= in_c;
    end
  end

  assign qm    = qm_q;
  assign blank = blank_q;
  assign c     = c_q;

endmodule

// File: rtl/tmds_encoder.sv
// DVI TMDS 8b/10b lane encoder: stage 1 q_m, stage 2 DC balance with running disparity.
// Define TMDS_OUT_REG_EN to add an output register (latency 3 instead of 2).
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEFAULT,
  parameter logic [1:0]  RST_TOKEN = 2'b00
) (
  input  logic       clk_pixel,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic [1:0] in_c,
  input  logic       in_blank,
  output logic [9:0] out_tmds
);

  localparam logic [9:0] RstSym = token(RST_TOKEN);

  logic [8:0] qm;
  logic       blank;
  logic [1:0] c;

  tmds_qm_stage #(
    .RST_TOKEN(RST_TOKEN)
  ) u_qm_stage (
    .clk_pixel(clk_pixel),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_c     (in_c),
    .in_blank (in_blank),
    .qm       (qm),
    .blank    (blank),
    .c        (c)
  );

  logic [3:0]              n1, n0;
  logic signed [4:0]       diff5;
  logic signed [CNT_W-1:0] diff, two, two_q8, two_nq8;
  logic signed [CNT_W-1:0] cnt_d, cnt_q;
  logic                    cnt_zero, cnt_neg, cnt_pos;
  logic [9:0]              tmds_d, tmds_q;

  always_comb begin
    n1       = popcount8(qm[7:0]);
    n0       = 4'd8 - n1;
    diff5    = signed'({1'b0, n1}) - signed'({1'b0, n0});
    diff     = CNT_W'(diff5);
    two      = CNT_W'(2);
    two_q8   = qm[8] ? two : '0;
    two_nq8  = qm[8] ? '0 : two;
    cnt_zero = (cnt_q == '0);
    cnt_neg  = cnt_q[CNT_W-1];
    cnt_pos  = !cnt_zero && !cnt_neg;

    tmds_d = {~qm[8], qm[8], qm[7:0]};
    cnt_d  = cnt_q;
    if (blank) begin
      tmds_d = token(c);
      cnt_d  = '0;
    end else if (cnt_zero || (n1 == n0)) begin
      tmds_d = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_d  = qm[8] ? (cnt_q + diff) : (cnt_q - diff);
    end else if ((cnt_pos && (n1 > n0)) || (cnt_neg && (n0 > n1))) begin
      // Invert to pull the running disparity back toward zero.
      tmds_d = {1'b1, qm[8], ~qm[7:0]};
      cnt_d  = cnt_q + two_q8 - diff;
    end else begin
      tmds_d = {1'b0, qm[8], qm[7:0]};
      cnt_d  = cnt_q + diff - two_nq8;
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      tmds_q <= RstSym;
      cnt_q  <= '0;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef TMDS_OUT_REG_EN
  logic [9:0] out_q;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= RstSym;
    end else begin
      out_q <= tmds_q;
    end
  end

  assign out_tmds = out_q;
`else
  assign out_tmds = tmds_q;
`endif

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: directed vector table, reset cases, random vs. model.
module tb_tmds_encoder;

  localparam int CNT_W = 6;
`ifdef TMDS_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk_pixel = 1'b0;
  logic       rst_n     = 1'b1;
  logic [7:0] in_data   = 8'h00;
  logic [1:0] in_c      = 2'b00;
  logic       in_blank  = 1'b1;
  logic [9:0] out_tmds;

  always #5 clk_pixel = ~clk_pixel;

  tmds_encoder #(
    .CNT_W    (CNT_W),
    .RST_TOKEN(2'b00)
  ) dut (
    .clk_pixel(clk_pixel),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_c     (in_c),
    .in_blank (in_blank),
    .out_tmds (out_tmds)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] c;
    logic       b;
    logic [9:0] e;
  } vec_t;

  typedef struct {
    logic [9:0] sym;
    logic       act;
    logic [7:0] d;
    int         idx;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_cnt = 0;
  exp_t expq[$];

  function automatic logic [9:0] tok(input logic [1:0] c);
    logic [9:0] t[4];
    t = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    return t[c];
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] q, d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  // Reference: build q_m, choose inversion, then track disparity as ones-minus-zeros of the symbol.
  task automatic model(input logic [7:0] d, input logic [1:0] c, input logic b,
                       output logic [9:0] sym);
    int         ones, n1;
    logic       use_xnor, inv;
    logic [8:0] q;
    if (b) begin
      sym   = tok(c);
      m_cnt = 0;
    end else begin
      ones     = $countones(d);
      use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      q[0]     = d[0];
      for (int i = 1; i < 8; i++) begin
        q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      end
      q[8] = ~use_xnor;
      n1   = $countones(q[7:0]);
      if (m_cnt == 0 || n1 == 4) inv = ~q[8];
      else inv = (m_cnt > 0 && n1 > 4) || (m_cnt < 0 && n1 < 4);
      sym   = {inv, q[8], inv ? ~q[7:0] : q[7:0]};
      m_cnt = m_cnt + 2 * $countones(sym) - 10;
    end
  endtask

  task automatic chk(input string name, input int idx, input logic [9:0] act,
                     input logic [9:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s idx=%0d got=%h want=%h", name, idx, act, want);
    end
  endtask

  task automatic prefill();
    exp_t e;
    expq.delete();
    m_cnt = 0;
    for (int i = 0; i < LAT - 1; i++) begin
      e.sym = 10'h354;
      e.act = 1'b0;
      e.d   = 8'h00;
      e.idx = -1;
      expq.push_back(e);
    end
  endtask

  task automatic step(input logic [7:0] d, input logic [1:0] c, input logic b,
                      input logic [9:0] want, input int idx);
    exp_t e;
    exp_t h;
    in_data  = d;
    in_c     = c;
    in_blank = b;
    e.sym = want;
    e.act = ~b;
    e.d   = d;
    e.idx = idx;
    expq.push_back(e);
    @(posedge clk_pixel);
    #1;
    h = expq.pop_front();
    chk("sym", h.idx, out_tmds, h.sym);
    if (h.act) chk("decode", h.idx, {2'b00, decode(out_tmds)}, {2'b00, h.d});
  endtask

  vec_t       tbl[11];
  logic [9:0] sym;
  logic [7:0] rd;
  logic [1:0] rc;
  logic       rb;
  int         lim;

  initial begin
    tbl[0]  = '{8'h00, 2'b00, 1'b0, 10'h100};
    tbl[1]  = '{8'h00, 2'b00, 1'b0, 10'h3FF};
    tbl[2]  = '{8'h00, 2'b00, 1'b0, 10'h100};
    tbl[3]  = '{8'hA5, 2'b00, 1'b1, 10'h354};
    tbl[4]  = '{8'h5A, 2'b01, 1'b1, 10'h0AB};
    tbl[5]  = '{8'hFF, 2'b10, 1'b1, 10'h154};
    tbl[6]  = '{8'h3C, 2'b11, 1'b1, 10'h2AB};
    tbl[7]  = '{8'h00, 2'b00, 1'b0, 10'h100};
    tbl[8]  = '{8'h00, 2'b00, 1'b1, 10'h354};
    tbl[9]  = '{8'hFF, 2'b00, 1'b0, 10'h200};
    tbl[10] = '{8'h00, 2'b11, 1'b1, 10'h2AB};

    // Power-on reset: asynchronous, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1 chk("reset_async", 0, out_tmds, 10'h354);
    repeat (3) @(posedge clk_pixel);
    #1 chk("reset_held", 0, out_tmds, 10'h354);
    rst_n = 1'b1;
    prefill();

    for (int i = 0; i < 11; i++) begin
      model(tbl[i].d, tbl[i].c, tbl[i].b, sym);
      step(tbl[i].d, tbl[i].c, tbl[i].b, tbl[i].e, i);
    end

    // Mid-frame reset while active symbols are in flight.
    for (int i = 0; i < 3; i++) begin
      model(8'h00, 2'b00, 1'b0, sym);
      step(8'h00, 2'b00, 1'b0, sym, 100 + i);
    end
    rst_n = 1'b0;
    #1 chk("reset_mid", 0, out_tmds, 10'h354);
    repeat (2) @(posedge clk_pixel);
    #1 chk("reset_mid_held", 0, out_tmds, 10'h354);
    rst_n = 1'b1;
    prefill();
    step(8'h00, 2'b00, 1'b0, 10'h100, 200);
    step(8'h00, 2'b00, 1'b0, 10'h3FF, 201);
    model(8'h00, 2'b00, 1'b0, sym);
    model(8'h00, 2'b00, 1'b0, sym);

    lim = (1 << (CNT_W - 1)) - 1;
    for (int i = 0; i < 10000; i++) begin
      rb = ($urandom_range(0, 7) == 0);
      rd = 8'($urandom);
      rc = 2'($urandom);
      model(rd, rc, rb, sym);
      step(rd, rc, rb, sym, 1000 + i);
      n_cmp++;
      if (m_cnt > lim || m_cnt < -lim) begin
        n_bad++;
        $display("FAIL cnt_bound idx=%0d got=%0d want=<=%0d", 1000 + i, m_cnt, lim);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
